// File: rtl/scara_pkg.sv
// Shared SCARA command definitions: the command word passed from the parser
// through this queue to the controller interface.
package scara_pkg;

  localparam int COORD_W = 14;

  typedef enum logic [3:0] {
    G00, G01, G20, G21, G90, G91, M2, M6, M72
  } cmd_code_e;

  typedef struct packed {
    cmd_code_e            cmd;
    logic [COORD_W-1:0]   x_value;
    logic [COORD_W-1:0]   y_value;
  } command_t;

  function automatic logic is_program_end(input command_t c);
    return c.cmd == M2;
  endfunction

endpackage

// File: rtl/cmd_fifo_mem.sv
// Command storage for the queue: one synchronous write port and an
// asynchronous read port so the head entry falls through without latency.
module cmd_fifo_mem
  import scara_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] wr_ptr_i,
  input  command_t         wr_data_i,
  input  logic [PTR_W-1:0] rd_ptr_i,
  output command_t         rd_data_o
);

  command_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_ptr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/gcode_command_queue.sv
// Command queue between the G-code parser and the controller interface.
// Program-end (M2) entries are consumed here and park the queue in HALT.
module gcode_command_queue
  import scara_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  command_t         wr_cmd,
  output logic             wr_ready,
  input  logic             flush,
  input  logic             start,
  input  logic             block,
  input  logic             controller_ready,
  output logic             memory_ready,
  output command_t         command_out,
  output logic             program_done,
  output logic             overflow,
  output logic [PTR_W:0]   level
);

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W + 1)'(DEPTH);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             overflow_q, overflow_d;

  command_t head;
  logic     empty, full, head_is_end;
  logic     push, pop_ext, drop_end, pop, mem_we;

  cmd_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk       (clk),
    .we_i      (mem_we),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i (wr_cmd),
    .rd_ptr_i  (rd_ptr_q),
    .rd_data_o (head)
  );

  assign empty       = (level_q == '0);
  assign full        = (level_q == LEVEL_FULL);
  assign head_is_end = is_program_end(head);

  // The consumer latches on exactly the pop_ext term, so it must stay in step.
  assign wr_ready     = ~full;
  assign memory_ready = ~empty & (state_q == ST_RUN) & ~head_is_end;
  assign push         = wr_valid & ~full;
  assign pop_ext      = memory_ready & controller_ready & ~block;
  assign drop_end     = ~empty & (state_q == ST_RUN) & head_is_end;
  assign pop          = pop_ext | drop_end;
  assign mem_we       = push & ~flush;

  assign command_out  = empty ? command_t'('0) : head;
  assign program_done = (state_q == ST_HALT);
  assign overflow     = overflow_q;
  assign level        = level_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (flush) begin
      state_d    = ST_RUN;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_valid & ~wr_ready) begin
        overflow_d = 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase

      unique case (state_q)
        ST_RUN:  if (drop_end) state_d = ST_HALT;
        ST_HALT: if (start)    state_d = ST_RUN;
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
